// File: rtl/simd_wb_queue.sv
// Writeback queue between one SIMD/SIMF ALU and the register-file write arbiter.
// Circular buffer; the oldest entry is presented to the arbiter until it is granted.
module simd_wb_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 2048,
    parameter int MASK_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int WFID_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_wr_valid,
    input  logic [WFID_WIDTH-1:0]     alu_wr_wfid,
    input  logic [ADDR_WIDTH-1:0]     alu_wr_addr,
    input  logic [MASK_WIDTH-1:0]     alu_wr_mask,
    input  logic [DATA_WIDTH-1:0]     alu_wr_data,
    output logic                      alu_stall,
    output logic                      queue_entry_valid,
    input  logic                      queue_entry_serviced,
    output logic [WFID_WIDTH-1:0]     wb_wfid,
    output logic [ADDR_WIDTH-1:0]     wb_addr,
    output logic [MASK_WIDTH-1:0]     wb_mask,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  not_empty;
    logic                  push;
    logic                  pop;

    logic [WFID_WIDTH-1:0] mem_wfid [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [MASK_WIDTH-1:0] mem_mask [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];

    // Stall depends only on registered count, keeping the arbiter grant off the ALU path.
    assign full      = (count == CW'(DEPTH));
    assign not_empty = (count != '0);
    assign push      = alu_wr_valid & ~full;
    assign pop       = queue_entry_serviced & not_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (alu_wr_valid && full) begin
                overflow_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_wfid[wr_ptr] <= alu_wr_wfid;
            mem_addr[wr_ptr] <= alu_wr_addr;
            mem_mask[wr_ptr] <= alu_wr_mask;
            mem_data[wr_ptr] <= alu_wr_data;
        end
    end

    assign alu_stall         = full;
    assign queue_entry_valid = not_empty;
    assign occupancy         = count;

    // Storage is not reset, so the head is masked to zero whenever nothing is queued.
    assign wb_wfid = not_empty ? mem_wfid[rd_ptr] : '0;
    assign wb_addr = not_empty ? mem_addr[rd_ptr] : '0;
    assign wb_mask = not_empty ? mem_mask[rd_ptr] : '0;
    assign wb_data = not_empty ? mem_data[rd_ptr] : '0;

endmodule

// File: tb/tb_simd_wb_queue.sv
// Self-checking bench for simd_wb_queue against a queue-based reference model.
module tb_simd_wb_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 2048;
    localparam int MW    = 64;
    localparam int AW    = 10;
    localparam int WW    = 6;
    localparam int OW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [WW-1:0] wfid;
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
        logic [DW-1:0] data;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alu_wr_valid = 1'b0;
    logic [WW-1:0] alu_wr_wfid = '0;
    logic [AW-1:0] alu_wr_addr = '0;
    logic [MW-1:0] alu_wr_mask = '0;
    logic [DW-1:0] alu_wr_data = '0;
    logic          alu_stall;
    logic          queue_entry_valid;
    logic          queue_entry_serviced = 1'b0;
    logic [WW-1:0] wb_wfid;
    logic [AW-1:0] wb_addr;
    logic [MW-1:0] wb_mask;
    logic [DW-1:0] wb_data;
    logic [OW-1:0] occupancy;
    logic          overflow_err;

    entry_t model_q[$];
    bit     model_ovf;
    int     n_checks = 0;
    int     n_errors = 0;

    simd_wb_queue #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ADDR_WIDTH(AW), .WFID_WIDTH(WW)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_wr_valid(alu_wr_valid), .alu_wr_wfid(alu_wr_wfid), .alu_wr_addr(alu_wr_addr),
        .alu_wr_mask(alu_wr_mask), .alu_wr_data(alu_wr_data), .alu_stall(alu_stall),
        .queue_entry_valid(queue_entry_valid), .queue_entry_serviced(queue_entry_serviced),
        .wb_wfid(wb_wfid), .wb_addr(wb_addr), .wb_mask(wb_mask), .wb_data(wb_data),
        .occupancy(occupancy), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [MW-1:0] rand_mask();
        logic [MW-1:0] m;
        m = {$urandom, $urandom};
        return m;
    endfunction

    // Drives one cycle from a negedge, advances the model at the posedge, returns at the next negedge.
    task automatic cycle(input logic v, input logic [WW-1:0] wf, input logic [AW-1:0] ad,
                         input logic [MW-1:0] mk, input logic [DW-1:0] dt, input logic serv);
        entry_t e;
        bit     was_full;
        alu_wr_valid         = v;
        alu_wr_wfid          = wf;
        alu_wr_addr          = ad;
        alu_wr_mask          = mk;
        alu_wr_data          = dt;
        queue_entry_serviced = serv;
        @(posedge clk);
        was_full = (model_q.size() == DEPTH);
        if (v && was_full) model_ovf = 1'b1;
        if (serv && model_q.size() > 0) void'(model_q.pop_front());
        if (v && !was_full) begin
            e.wfid = wf; e.addr = ad; e.mask = mk; e.data = dt;
            model_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        alu_wr_valid = 1'b0;
        queue_entry_serviced = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({alu_stall, queue_entry_valid, overflow_err} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_flags: stall/valid/ovf=%b expected 000",
                     {alu_stall, queue_entry_valid, overflow_err});
        end
        n_checks++;
        if (occupancy !== '0) begin
            n_errors++;
            $display("FAIL reset_occupancy: got %0d expected 0", occupancy);
        end
        n_checks++;
        if (wb_wfid !== '0 || wb_addr !== '0 || wb_mask !== '0 || wb_data !== '0) begin
            n_errors++;
            $display("FAIL reset_wb: addr=%h wfid=%h expected 0", wb_addr, wb_wfid);
        end
        rst = 1'b1;
    endtask

    task automatic test_single_push();
        logic [DW-1:0] pat_a;
        logic [MW-1:0] ones;
        pat_a = {64{32'hA5A5_0F0F}};
        ones  = '1;
        cycle(1'b1, 6'h11, 10'h005, ones, pat_a, 1'b0);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (queue_entry_valid !== 1'b1 || wb_addr !== 10'h005 || occupancy !== OW'(1)) begin
                n_errors++;
                $display("FAIL single_hold[%0d]: valid=%b addr=%h occ=%0d expected 1/005/1",
                         i, queue_entry_valid, wb_addr, occupancy);
            end
            idle();
        end
        n_checks++;
        if (wb_data !== pat_a || wb_mask !== ones || wb_wfid !== 6'h11) begin
            n_errors++;
            $display("FAIL single_payload: data[31:0]=%h wfid=%h expected a5a50f0f/11",
                     wb_data[31:0], wb_wfid);
        end
        cycle(1'b0, '0, '0, '0, '0, 1'b1);
        queue_entry_serviced = 1'b0;
        n_checks++;
        if (queue_entry_valid !== 1'b0 || occupancy !== '0 || wb_addr !== '0) begin
            n_errors++;
            $display("FAIL single_retire: valid=%b occ=%0d addr=%h expected 0/0/0",
                     queue_entry_valid, occupancy, wb_addr);
        end
    endtask

    task automatic test_fill_overflow();
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, WW'($urandom), AW'(i), rand_mask(), rand_data(), 1'b0);
            n_checks++;
            if (alu_stall !== (i == 4) || occupancy !== OW'(i)) begin
                n_errors++;
                $display("FAIL fill[%0d]: stall=%b occ=%0d expected %0d/%0d",
                         i, alu_stall, occupancy, (i == 4), i);
            end
        end
        cycle(1'b1, '0, 10'h055, '1, rand_data(), 1'b0);
        n_checks++;
        if (overflow_err !== 1'b1 || occupancy !== OW'(4) || alu_stall !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow: ovf=%b occ=%0d stall=%b expected 1/4/1",
                     overflow_err, occupancy, alu_stall);
        end
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (wb_addr !== AW'(i) || wb_data !== model_q[0].data || wb_mask !== model_q[0].mask
                || wb_wfid !== model_q[0].wfid) begin
                n_errors++;
                $display("FAIL drain[%0d]: addr=%h data[31:0]=%h expected %h/%h",
                         i, wb_addr, wb_data[31:0], i, model_q[0].data[31:0]);
            end
            cycle(1'b0, '0, '0, '0, '0, 1'b1);
        end
        queue_entry_serviced = 1'b0;
        n_checks++;
        if (queue_entry_valid !== 1'b0 || occupancy !== '0 || overflow_err !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_end: valid=%b occ=%0d ovf=%b expected 0/0/1",
                     queue_entry_valid, occupancy, overflow_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] next_addr;
        logic [AW-1:0] expect_head;
        apply_reset();
        next_addr = 10'h100;
        expect_head = 10'h100;
        cycle(1'b1, WW'($urandom), next_addr, rand_mask(), rand_data(), 1'b0);
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (occupancy !== OW'(1) || queue_entry_valid !== 1'b1 || wb_addr !== expect_head
                || wb_data !== model_q[0].data) begin
                n_errors++;
                $display("FAIL stream[%0d]: occ=%0d addr=%h expected 1/%h",
                         i, occupancy, wb_addr, expect_head);
            end
            next_addr = next_addr + 1'b1;
            cycle(1'b1, WW'($urandom), next_addr, rand_mask(), rand_data(), 1'b1);
            expect_head = expect_head + 1'b1;
        end
        cycle(1'b0, '0, '0, '0, '0, 1'b1);
        queue_entry_serviced = 1'b0;
        n_checks++;
        if (occupancy !== '0 || queue_entry_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL stream_end: occ=%0d valid=%b expected 0/0", occupancy, queue_entry_valid);
        end
    endtask

    task automatic test_empty_service();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, '0, '0, '0, 1'b1);
            n_checks++;
            if (occupancy !== '0 || queue_entry_valid !== 1'b0 || overflow_err !== 1'b0) begin
                n_errors++;
                $display("FAIL empty_service[%0d]: occ=%0d valid=%b ovf=%b expected 0/0/0",
                         i, occupancy, queue_entry_valid, overflow_err);
            end
        end
        queue_entry_serviced = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, WW'($urandom), AW'(10'h20 + i), rand_mask(), rand_data(), 1'b0);
        alu_wr_valid = 1'b0;
        queue_entry_serviced = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (queue_entry_valid !== 1'b0 || occupancy !== '0 || wb_addr !== '0 || wb_data !== '0
            || wb_mask !== '0 || wb_wfid !== '0) begin
            n_errors++;
            $display("FAIL async_reset: valid=%b occ=%0d addr=%h expected 0/0/0",
                     queue_entry_valid, occupancy, wb_addr);
        end
        model_q.delete();
        model_ovf = 1'b0;
        @(negedge clk);
        queue_entry_serviced = 1'b0;
        rst = 1'b1;
        cycle(1'b1, 6'h3F, 10'h3FF, '1, rand_data(), 1'b0);
        n_checks++;
        if (queue_entry_valid !== 1'b1 || wb_addr !== 10'h3FF || occupancy !== OW'(1)
            || wb_data !== model_q[0].data) begin
            n_errors++;
            $display("FAIL post_reset_push: valid=%b addr=%h occ=%0d expected 1/3ff/1",
                     queue_entry_valid, wb_addr, occupancy);
        end
    endtask

    task automatic test_full_pop_push();
        apply_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b1, WW'($urandom), AW'(10'h40 + i), rand_mask(), rand_data(), 1'b0);
        cycle(1'b1, '0, 10'h2AA, '1, rand_data(), 1'b1);
        n_checks++;
        if (overflow_err !== 1'b1 || occupancy !== OW'(3) || alu_stall !== 1'b0 || wb_addr !== 10'h042) begin
            n_errors++;
            $display("FAIL full_pop_push: ovf=%b occ=%0d stall=%b addr=%h expected 1/3/0/042",
                     overflow_err, occupancy, alu_stall, wb_addr);
        end
        for (int i = 2; i <= 4; i++) begin
            n_checks++;
            if (wb_addr !== AW'(10'h40 + i)) begin
                n_errors++;
                $display("FAIL full_pop_push_drain[%0d]: addr=%h expected %h", i, wb_addr, 10'h40 + i);
            end
            cycle(1'b0, '0, '0, '0, '0, 1'b1);
        end
        queue_entry_serviced = 1'b0;
    endtask

    task automatic test_random();
        logic exp_valid;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic [MW-1:0] exp_mask;
        logic [WW-1:0] exp_wfid;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 99) < 60), WW'($urandom), AW'($urandom), rand_mask(), rand_data(),
                  ($urandom_range(0, 99) < 50));
            exp_valid = (model_q.size() != 0);
            exp_addr  = exp_valid ? model_q[0].addr : '0;
            exp_data  = exp_valid ? model_q[0].data : '0;
            exp_mask  = exp_valid ? model_q[0].mask : '0;
            exp_wfid  = exp_valid ? model_q[0].wfid : '0;
            n_checks++;
            if (queue_entry_valid !== exp_valid || occupancy !== OW'(model_q.size())
                || alu_stall !== (model_q.size() == DEPTH) || overflow_err !== model_ovf
                || wb_addr !== exp_addr || wb_data !== exp_data || wb_mask !== exp_mask
                || wb_wfid !== exp_wfid) begin
                n_errors++;
                $display("FAIL random[%0d]: valid=%b occ=%0d stall=%b ovf=%b addr=%h expected %b/%0d/%b/%b/%h",
                         i, queue_entry_valid, occupancy, alu_stall, overflow_err, wb_addr,
                         exp_valid, model_q.size(), (model_q.size() == DEPTH), model_ovf, exp_addr);
            end
        end
        alu_wr_valid = 1'b0;
        queue_entry_serviced = 1'b0;
    endtask

    initial begin
        model_ovf = 1'b0;
        test_reset();
        test_single_push();
        test_fill_overflow();
        test_back_to_back();
        test_empty_service();
        test_async_reset();
        test_full_pop_push();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/simd_wb_queue.md
# simd_wb_queue

Per-functional-unit writeback queue that sits directly upstream of the register-file write arbiter. It buffers vector results produced by one SIMD/SIMF ALU and presents the oldest one to the arbiter through the `queue_entry_valid` / `queue_entry_serviced` handshake. It retires an entry on the cycle the arbiter grants the write port. One instance exists per SIMD and per SIMF unit, eight in total.

## Interface

Parameters:
- `DEPTH`, 4: number of entries; must be a power of two, 2..16.
- `DATA_WIDTH`, 2048: writeback data, 64 lanes × 32 bits.
- `MASK_WIDTH`, 64: per-lane write-enable mask.
- `ADDR_WIDTH`, 10: destination register address.
- `WFID_WIDTH`, 6: wavefront id.

Ports:
- `clk` in 1: clock. One clock; reset is asynchronous and active-low.
- `rst` in 1: asynchronous, active-low reset.
- `alu_wr_valid` in 1: ALU presents a result this cycle.
- `alu_wr_wfid` in WFID_WIDTH: wavefront of the result.
- `alu_wr_addr` in ADDR_WIDTH: destination register.
- `alu_wr_mask` in MASK_WIDTH: lane write mask.
- `alu_wr_data` in DATA_WIDTH: result data.
- `alu_stall` out 1: queue full; the ALU must not present a result.
- `queue_entry_valid` out 1: head entry available to the arbiter.
- `queue_entry_serviced` in 1: arbiter grant; retire the head at this edge.
- `wb_wfid` out WFID_WIDTH: head entry wavefront id.
- `wb_addr` out ADDR_WIDTH: head entry destination register.
- `wb_mask` out MASK_WIDTH: head entry lane write mask.
- `wb_data` out DATA_WIDTH: head entry data.
- `occupancy` out log2(DEPTH)+1: number of valid entries.
- `overflow_err` out 1: sticky; set when a push arrives while full.

## Operation

- Circular buffer built from `wr_ptr`, `rd_ptr` (log2(DEPTH) bits, natural wrap) and a count register of log2(DEPTH)+1 bits.
- Occupancy states:
  - EMPTY: count = 0.
  - PARTIAL: 0 < count < DEPTH.
  - FULL: count = DEPTH.
- Push: `alu_wr_valid & ~full`. The entry is written at `wr_ptr`, then `wr_ptr` increments.
- Pop: `queue_entry_serviced & queue_entry_valid`. `rd_ptr` increments.
- `queue_entry_serviced` while empty is ignored; there is no state change and no error.
- Simultaneous push and pop:
  - Non-empty queue: both happen and count is unchanged.
  - Empty queue: only the push happens, because valid is still 0.
- `alu_stall` = FULL. It is a pure function of registered count and never depends on `queue_entry_serviced`, so there is no combinational path from the arbiter to the ALU.
- Push attempt while FULL, whether or not a pop occurs in the same cycle:
  - The data is dropped.
  - `overflow_err` sets and stays set until reset.
- `queue_entry_valid` = (count != 0).
- `wb_*` are driven from the `rd_ptr` entry.
  - They are forced to 0 when empty.
  - They are stable while valid is high and no pop occurs.
- Reset (asynchronous assertion, synchronous deassertion handled upstream):
  - Pointers, count and `overflow_err` clear.
  - All outputs go to 0.
  - Storage contents need no reset.
  - Reset asserted mid-operation discards all entries immediately.

## Timing

- Push-to-valid latency is 1 cycle. A result pushed at edge N is visible as `queue_entry_valid`/`wb_*` in the cycle after edge N.
- The arbiter samples valid and `wb_*` combinationally and asserts `queue_entry_serviced` in the same cycle. Retirement occurs at the next edge.
- Throughput is one push and one pop per cycle. Back-to-back grants drain one entry per cycle.
- `wb_*` for the next entry appear in the cycle after a pop. There are no bubbles when the queue holds ≥2 entries.
- `occupancy`, `alu_stall` and `queue_entry_valid` all update at the same edge as the pointer change.
- Reset values of every output:
  - `alu_stall` = 0
  - `queue_entry_valid` = 0
  - `wb_*` = 0
  - `occupancy` = 0
  - `overflow_err` = 0

## Test plan

- Reset then single push (addr=0x05, mask=all ones, data pattern A), with serviced held 0:
  - Valid rises 1 cycle later.
  - `wb_addr`=0x05 and `occupancy`=1, holding indefinitely.
  - Assert serviced for 1 cycle: valid falls and `occupancy`=0 next cycle.
- Push 4 entries (addr 1..4) with no service:
  - `alu_stall`=1 after the 4th push.
  - A 5th push with valid held sets `overflow_err`=1; `occupancy` stays 4.
  - Draining returns addr 1,2,3,4 in order, one per cycle.
- Continuous push and service every cycle for 20 cycles:
  - `occupancy` stays 1.
  - Pointers wrap ≥4 times.
  - `wb_addr` sequence matches push order with no gaps.
- `queue_entry_serviced` pulsed while empty:
  - `occupancy` stays 0, valid stays 0, `overflow_err` stays 0.
- With 3 entries queued and service in progress, assert `rst` low asynchronously mid-cycle:
  - Valid, `occupancy` and `wb_*` go 0 immediately.
  - After release, a new push (addr=0x3FF) appears as head.
- Full queue with simultaneous pop and push:
  - Push is dropped, `overflow_err`=1, `occupancy`=3.
  - `alu_stall` deasserts next cycle.
